// File: rtl/float_decoder.sv
// Sign/exponent/significand to 12-bit two's-complement converter.
// Serial shifter: one exponent step per clock, result held until taken.
module float_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign,
  input  logic [2:0]  exponent,
  input  logic [3:0]  significand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out,
  output logic        nonnorm
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [11:0] mag;
  logic [2:0]  cnt;
  logic        sgn;
  logic        pend;

  assign in_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mag       <= '0;
      cnt       <= '0;
      sgn       <= 1'b0;
      pend      <= 1'b0;
      out       <= '0;
      nonnorm   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mag  <= {8'b0, significand};
            cnt  <= exponent;
            sgn  <= sign;
            pend <= (exponent != '0) && !significand[3];
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            mag <= mag << 1;
            cnt <= cnt - 3'd1;
          end else begin
            // negating zero yields zero, so -0 needs no special case
            out       <= sgn ? (~mag + 12'd1) : mag;
            nonnorm   <= pend;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
